// File: rtl/prefetch_fifo.sv
`default_nettype none
// ============================================================================
// Module      : prefetch_fifo
// Description : Parametrised first-word-fall-through FIFO with registered
//               output. Inferred dual-port RAM (registered read) feeds a
//               two-stage output pipeline (middle -> dout). Provides full,
//               almost_full, occupancy count and overflow/underflow pulses.
//               Optional high-water mark enabled by the macro
//               PREFETCH_FIFO_HWM_EN (hwm reads 0 when it is not defined).
// Revision    : 1.0 - initial parametrised release
// ============================================================================
module prefetch_fifo #(
  parameter int DELAY        = 1,
  parameter int WIDTH        = 32,
  parameter int DEPTH_LOG2   = 4,
  parameter int AFULL_MARGIN = 2
) (
  input  logic                  CLK,
  input  logic                  RESET_N,
  input  logic                  wren,
  input  logic [WIDTH-1:0]      din,
  output logic                  full,
  output logic                  almost_full,
  output logic                  overflow,
  input  logic                  rden,
  output logic [WIDTH-1:0]      dout,
  output logic                  valid,
  output logic                  empty,
  output logic                  underflow,
  output logic [DEPTH_LOG2+1:0] count,
  output logic [DEPTH_LOG2+1:0] hwm
);

  // --------------------------------------------------------------------------
  // Derived constants
  // --------------------------------------------------------------------------
  localparam int c_ram_depth = 2 ** DEPTH_LOG2;
  localparam int c_cap       = c_ram_depth + 2;   // RAM + middle + dout
  localparam int c_cw        = DEPTH_LOG2 + 2;    // count width
  localparam int c_pw        = DEPTH_LOG2 + 1;    // pointer width (wrap bit)

  localparam logic [c_cw-1:0] c_cap_cnt       = c_cw'(c_cap);
  // A margin at or above the capacity would make the threshold negative;
  // in that case almost_full is simply held high.
  localparam bit              c_afull_always  = (AFULL_MARGIN >= c_cap);
  localparam logic [c_cw-1:0] c_afull_cnt     = c_afull_always ? '0
                                                : c_cw'(c_cap - AFULL_MARGIN);

  // DELAY only existed to skew nonblocking updates in simulation of the
  // previous FIFO; it is accepted for drop-in compatibility and has no
  // effect on this implementation.
  if (DELAY < 0) begin : g_delay_unused
  end

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [WIDTH-1:0] ram_mem [c_ram_depth];
  logic [WIDTH-1:0] ram_rdata_q;

  logic [c_pw-1:0]  wr_ptr_q, wr_ptr_d;
  logic [c_pw-1:0]  rd_ptr_q, rd_ptr_d;
  logic [c_cw-1:0]  count_q, count_d;
  logic             ram_valid_q, ram_valid_d;
  logic [WIDTH-1:0] middle_q, middle_d;
  logic             middle_valid_q, middle_valid_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             dout_valid_q, dout_valid_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;

  // --------------------------------------------------------------------------
  // Control terms (all derived from registered state plus wren/rden)
  // --------------------------------------------------------------------------
  logic                  full_int;
  logic                  wr_accept;
  logic                  rd_accept;
  logic                  ram_empty;
  logic                  ram_rd_en;
  logic                  dout_update;
  logic                  middle_load;
  logic                  ram_consume;
  logic [DEPTH_LOG2-1:0] wr_addr;
  logic [DEPTH_LOG2-1:0] rd_addr;

  assign full_int  = (count_q == c_cap_cnt);
  assign wr_accept = wren & ~full_int;
  assign rd_accept = rden & dout_valid_q;
  assign ram_empty = (wr_ptr_q == rd_ptr_q);
  assign wr_addr   = wr_ptr_q[DEPTH_LOG2-1:0];
  assign rd_addr   = rd_ptr_q[DEPTH_LOG2-1:0];

  // dout reloads when something is waiting upstream and dout is either being
  // consumed or currently empty; middle always has priority over the RAM word.
  assign dout_update = (middle_valid_q | ram_valid_q) & (rden | ~dout_valid_q);

  // The RAM word parks in middle when dout is busy and middle is free, or
  // replaces middle when middle moves on into dout.
  assign middle_load = ram_valid_q & (middle_valid_q == dout_update);

  // The RAM read register is freed if its word went to middle or straight to dout.
  assign ram_consume = ram_valid_q & (middle_load | (dout_update & ~middle_valid_q));

  // Only hold off a new read when all three stages are occupied; in every other
  // state the read register is guaranteed free by the next edge.
  assign ram_rd_en = ~ram_empty & ~(ram_valid_q & middle_valid_q & dout_valid_q);

  // --------------------------------------------------------------------------
  // Next-state computation for pointers, pipeline stages, count and pulses
  // --------------------------------------------------------------------------
  always_comb begin
    wr_ptr_d       = wr_ptr_q;
    rd_ptr_d       = rd_ptr_q;
    count_d        = count_q;
    ram_valid_d    = ram_valid_q;
    middle_d       = middle_q;
    middle_valid_d = middle_valid_q;
    dout_d         = dout_q;
    dout_valid_d   = dout_valid_q;
    overflow_d     = wren & full_int;
    underflow_d    = rden & ~dout_valid_q;

    if (wr_accept) begin
      wr_ptr_d = wr_ptr_q + c_pw'(1);
    end
    if (ram_rd_en) begin
      rd_ptr_d = rd_ptr_q + c_pw'(1);
    end

    ram_valid_d = ram_rd_en | (ram_valid_q & ~ram_consume);

    if (middle_load) begin
      middle_d       = ram_rdata_q;
      middle_valid_d = 1'b1;
    end else if (dout_update && middle_valid_q) begin
      middle_valid_d = 1'b0;
    end

    if (dout_update) begin
      dout_d       = middle_valid_q ? middle_q : ram_rdata_q;
      dout_valid_d = 1'b1;
    end else if (rd_accept) begin
      dout_valid_d = 1'b0;
    end

    case ({wr_accept, rd_accept})
      2'b10:   count_d = count_q + c_cw'(1);
      2'b01:   count_d = count_q - c_cw'(1);
      default: count_d = count_q;
    endcase
  end

  // Control and output registers, cleared asynchronously
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      ram_valid_q    <= 1'b0;
      middle_q       <= '0;
      middle_valid_q <= 1'b0;
      dout_q         <= '0;
      dout_valid_q   <= 1'b0;
      overflow_q     <= 1'b0;
      underflow_q    <= 1'b0;
    end else begin
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      ram_valid_q    <= ram_valid_d;
      middle_q       <= middle_d;
      middle_valid_q <= middle_valid_d;
      dout_q         <= dout_d;
      dout_valid_q   <= dout_valid_d;
      overflow_q     <= overflow_d;
      underflow_q    <= underflow_d;
    end
  end

  // Inferred dual-port RAM: synchronous write, registered read (no reset so it
  // maps onto block RAM). Read and write addresses never collide because a
  // read is only issued while the RAM holds at least one unread word.
  always_ff @(posedge CLK) begin
    if (wr_accept) begin
      ram_mem[wr_addr] <= din;
    end
    if (ram_rd_en) begin
      ram_rdata_q <= ram_mem[rd_addr];
    end
  end

`ifdef PREFETCH_FIFO_HWM_EN
  logic [c_cw-1:0] hwm_q, hwm_d;

  // High-water mark tracks the largest registered occupancy since reset
  always_comb begin
    hwm_d = hwm_q;
    if (count_q > hwm_q) begin
      hwm_d = count_q;
    end
  end

  // High-water mark register, cleared only by reset
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      hwm_q <= '0;
    end else begin
      hwm_q <= hwm_d;
    end
  end

  assign hwm = hwm_q;
`else
  assign hwm = '0;
`endif

  // --------------------------------------------------------------------------
  // Outputs: all status flags come from registered state only
  // --------------------------------------------------------------------------
  assign full        = full_int;
  assign almost_full = c_afull_always | (count_q >= c_afull_cnt);
  assign overflow    = overflow_q;
  assign underflow   = underflow_q;
  assign dout        = dout_q;
  assign valid       = dout_valid_q;
  assign empty       = ~dout_valid_q;
  assign count       = count_q;

endmodule
`default_nettype wire

// File: tb/tb_prefetch_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_prefetch_fifo
// Description : Self-checking bench for prefetch_fifo. Writes push expected
//               words into a scoreboard queue; a negedge monitor pops and
//               compares every word the DUT hands over (valid & rden).
//               Status outputs are checked inline against hand-derived values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_prefetch_fifo;

  localparam int WIDTH        = 32;
  localparam int DEPTH_LOG2   = 4;
  localparam int AFULL_MARGIN = 2;
  localparam int CW           = DEPTH_LOG2 + 2;

`ifdef PREFETCH_FIFO_HWM_EN
  localparam bit HWM_EN = 1'b1;
`else
  localparam bit HWM_EN = 1'b0;
`endif

  logic             CLK = 1'b0;
  logic             RESET_N;
  logic             wren;
  logic [WIDTH-1:0] din;
  logic             full;
  logic             almost_full;
  logic             overflow;
  logic             rden;
  logic [WIDTH-1:0] dout;
  logic             valid;
  logic             empty;
  logic             underflow;
  logic [CW-1:0]    count;
  logic [CW-1:0]    hwm;

  int n_checks = 0;
  int n_fail   = 0;

  logic [WIDTH-1:0] exp_q[$];
  logic [WIDTH-1:0] exp_word;

  prefetch_fifo #(
    .DELAY        (1),
    .WIDTH        (WIDTH),
    .DEPTH_LOG2   (DEPTH_LOG2),
    .AFULL_MARGIN (AFULL_MARGIN)
  ) dut (
    .CLK         (CLK),
    .RESET_N     (RESET_N),
    .wren        (wren),
    .din         (din),
    .full        (full),
    .almost_full (almost_full),
    .overflow    (overflow),
    .rden        (rden),
    .dout        (dout),
    .valid       (valid),
    .empty       (empty),
    .underflow   (underflow),
    .count       (count),
    .hwm         (hwm)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic push_write(input logic [WIDTH-1:0] d);
    wren = 1'b1;
    din  = d;
    exp_q.push_back(d);
    cyc();
    wren = 1'b0;
  endtask

  task automatic pop_read();
    rden = 1'b1;
    cyc();
    rden = 1'b0;
  endtask

  task automatic do_reset();
    RESET_N = 1'b0;
    wren    = 1'b0;
    rden    = 1'b0;
    exp_q.delete();
    cyc();
    cyc();
    RESET_N = 1'b1;
  endtask

  // Scoreboard monitor: every accepted read must deliver the oldest expected word
  always @(negedge CLK) begin
    if (RESET_N === 1'b1 && valid === 1'b1 && rden === 1'b1) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL scoreboard: got 0x%0h, expected no word (t=%0t)", dout, $time);
      end else begin
        exp_word = exp_q.pop_front();
        if (dout !== exp_word) begin
          n_fail++;
          $display("FAIL scoreboard: got 0x%0h, expected 0x%0h (t=%0t)", dout, exp_word, $time);
        end
      end
    end
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int drops;
    int bad_count;

    RESET_N = 1'b0;
    wren    = 1'b0;
    rden    = 1'b0;
    din     = '0;

    // ---------------- reset values while reset is held ----------------
    #12;
    check("rst_empty",       empty,       1);
    check("rst_valid",       valid,       0);
    check("rst_full",        full,        0);
    check("rst_almost_full", almost_full, 0);
    check("rst_overflow",    overflow,    0);
    check("rst_underflow",   underflow,   0);
    check("rst_count",       count,       0);
    check("rst_dout",        dout,        0);
    check("rst_hwm",         hwm,         0);
    cyc();
    RESET_N = 1'b1;
    cyc();

    // ---------------- underflow on empty ----------------
    rden = 1'b1;
    cyc();
    rden = 1'b0;
    check("uf_pulse", underflow, 1);
    check("uf_count", count,     0);
    check("uf_dout",  dout,      0);
    check("uf_empty", empty,     1);
    cyc();
    check("uf_pulse_end", underflow, 0);

    // ---------------- single write latency ----------------
    push_write(32'hA5);
    check("lat_c1_empty", empty, 1);
    check("lat_c1_count", count, 1);
    cyc();
    check("lat_c2_empty", empty, 1);
    cyc();
    check("lat_c3_valid", valid, 1);
    check("lat_c3_dout",  dout,  32'hA5);
    check("lat_c3_count", count, 1);
    pop_read();
    check("lat_rd_count", count, 0);
    check("lat_rd_empty", empty, 1);

    // ---------------- fill to capacity, overflow, drain ----------------
    for (int i = 0; i < 18; i++) begin
      push_write(32'(i));
      check("fill_count", count,       64'(i + 1));
      check("fill_afull", almost_full, (i >= 15) ? 1 : 0);
      check("fill_full",  full,        (i == 17) ? 1 : 0);
    end
    wren = 1'b1;
    din  = 32'd18;
    cyc();
    wren = 1'b0;
    check("ovf_pulse", overflow, 1);
    check("ovf_count", count,    18);
    check("ovf_full",  full,     1);
    cyc();
    check("ovf_pulse_end", overflow, 0);
    check("ovf_count_2",   count,    18);
    check("hwm_full",      hwm,      HWM_EN ? 18 : 0);
    rden = 1'b1;
    repeat (18) cyc();
    rden = 1'b0;
    check("drain_count", count,          0);
    check("drain_empty", empty,          1);
    check("drain_queue", exp_q.size(),   0);

    // ---------------- sustained read/write at occupancy 10 ----------------
    for (int i = 0; i < 10; i++) push_write(32'(100 + i));
    cyc();
    cyc();
    check("stream_pre_count", count, 10);
    check("stream_pre_valid", valid, 1);
    drops     = 0;
    bad_count = 0;
    wren = 1'b1;
    rden = 1'b1;
    for (int i = 0; i < 100; i++) begin
      din = 32'(200 + i);
      exp_q.push_back(32'(200 + i));
      cyc();
      if (valid !== 1'b1) drops++;
      if (count !== CW'(10)) bad_count++;
    end
    wren = 1'b0;
    check("stream_valid_drops", drops,     0);
    check("stream_count_moves", bad_count, 0);
    repeat (10) cyc();
    rden = 1'b0;
    check("stream_drain_count", count,        0);
    check("stream_drain_queue", exp_q.size(), 0);

    // ---------------- asynchronous reset mid-cycle ----------------
    for (int i = 0; i < 12; i++) push_write(32'(300 + i));
    check("mid_fill_count", count, 12);
    #2;
    RESET_N = 1'b0;
    #1;
    check("async_count", count,       0);
    check("async_empty", empty,       1);
    check("async_valid", valid,       0);
    check("async_full",  full,        0);
    check("async_afull", almost_full, 0);
    check("async_dout",  dout,        0);
    exp_q.delete();
    @(posedge CLK);
    #1;
    RESET_N = 1'b1;
    push_write(32'h3C);
    check("post_rst_c1_empty", empty, 1);
    cyc();
    check("post_rst_c2_empty", empty, 1);
    cyc();
    check("post_rst_c3_valid", valid, 1);
    check("post_rst_c3_dout",  dout,  32'h3C);
    pop_read();

    // ---------------- high-water mark ----------------
    do_reset();
    check("hwm_after_reset", hwm, 0);
    for (int i = 0; i < 7; i++) push_write(32'(400 + i));
    rden = 1'b1;
    repeat (7) cyc();
    rden = 1'b0;
    for (int i = 0; i < 3; i++) push_write(32'(500 + i));
    cyc();
    cyc();
    check("hwm_value",  hwm,   HWM_EN ? 7 : 0);
    check("hwm_count3", count, 3);
    rden = 1'b1;
    repeat (3) cyc();
    rden = 1'b0;
    check("final_count", count,        0);
    check("final_queue", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
